// File: rtl/starfield_gen.sv
// starfield_gen
// Procedural starfield pixel source placed directly after the 480p timing
// generator. A 17-bit LFSR advances once per active pixel. A pixel becomes a
// greyscale star when the LFSR's upper byte reaches THRESH. During vertical
// blanking the LFSR is pre-advanced by a per-frame growing offset, so the
// field scrolls from one frame to the next. The synchros leave delay-matched
// to the pixel data: both outputs are registered two cycles after the input.
module starfield_gen #(
    parameter logic [16:0] SEED   = 17'h1ACE1,  // frame-start LFSR value, nonzero
    parameter logic [7:0]  THRESH = 8'hFF,      // star when lfsr[16:9] >= THRESH
    parameter logic [9:0]  SPEED  = 10'd1       // skip growth per frame
) (
    input  logic        CLK_i,
    input  logic        RST_N_i,
    input  logic [2:0]  VID_HVD_i,    // {HS, VS, DE}, active high
    output logic [2:0]  VID_HVD_o,    // VID_HVD_i delayed two cycles
    output logic [23:0] VID_RGB_o,    // {R,G,B}, aligned with VID_HVD_o
    output logic [1:0]  DBG_STATE_o   // current sequencer state
);

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,  // no frame seen since reset: black output
        ST_SKIP    = 2'd1,  // vertical blanking: pre-advancing the LFSR
        ST_RUN     = 2'd2   // active video: one LFSR step per DE pixel
    } state_t;

    state_t      state;

    // Input pipeline. hvd_q is the stage where the pixel is evaluated.
    // hvd_qq sits beside the pixel register and feeds the synchro output.
    logic [2:0]  hvd_q;
    logic [2:0]  hvd_qq;

    logic [16:0] lfsr;
    logic [16:0] lfsr_next;
    logic [7:0]  frame_ctr;
    logic [9:0]  skip_base;
    logic [9:0]  skip_base_next;
    logic [9:0]  skip_ctr;

    logic        vs_rise;
    logic        de_q;
    logic        pix_live;
    logic        star;
    logic [7:0]  lum;
    logic [23:0] rgb_d;
    logic [23:0] rgb_q;

    // A frame starts on the VS rising edge, seen at the evaluation stage.
    assign vs_rise        = hvd_q[1] & ~hvd_qq[1];
    assign de_q           = hvd_q[0];
    assign skip_base_next = skip_base + SPEED;

    // LFSR successor. The all-zero state would lock up, so it moves to 1.
    always_comb begin
        lfsr_next = {lfsr[15:0], lfsr[16] ^ lfsr[13]};
        if (lfsr == 17'h0) begin
            lfsr_next = 17'h1;
        end
    end

    // Pixel value for the sample now at hvd_q. A DE pixel that arrives in SKIP
    // is taken as the first RUN pixel. A frame-start cycle is always black.
    always_comb begin
        pix_live = de_q & ~vs_rise & ((state == ST_RUN) | (state == ST_SKIP));
        star     = pix_live & (lfsr[16:9] >= THRESH);
        lum      = lfsr[7:0] + frame_ctr;
        rgb_d    = star ? {lum, lum, lum} : 24'h0;
    end

    // Synchro pipeline and pixel register. Both outputs come from flops.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            hvd_q  <= 3'b000;
            hvd_qq <= 3'b000;
            rgb_q  <= 24'h0;
        end else begin
            hvd_q  <= VID_HVD_i;
            hvd_qq <= hvd_q;
            rgb_q  <= rgb_d;
        end
    end

    // Frame sequencer. It owns the LFSR, the frame counter and the skip
    // bookkeeping. A frame start overrides whatever the current state would do.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state     <= ST_WAIT_VS;
            lfsr      <= SEED;
            frame_ctr <= 8'h00;
            skip_base <= 10'd0;
            skip_ctr  <= 10'd0;
        end else if (vs_rise) begin
            lfsr      <= SEED;
            frame_ctr <= frame_ctr + 8'd1;
            skip_base <= skip_base_next;
            skip_ctr  <= skip_base_next;
            state     <= ST_SKIP;
        end else begin
            case (state)
                ST_WAIT_VS: begin
                    // Hold everything until a frame boundary is seen.
                end
                ST_SKIP: begin
                    if (de_q) begin
                        // Active video arrived early: drop the rest of the skip
                        // and step for this pixel as RUN would.
                        lfsr     <= lfsr_next;
                        skip_ctr <= 10'd0;
                        state    <= ST_RUN;
                    end else if (skip_ctr != 10'd0) begin
                        lfsr     <= lfsr_next;
                        skip_ctr <= skip_ctr - 10'd1;
                    end else begin
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Step only on active pixels. Horizontal blanking holds.
                    if (de_q) begin
                        lfsr <= lfsr_next;
                    end
                end
                default: begin
                    state <= ST_WAIT_VS;
                end
            endcase
        end
    end

    assign VID_HVD_o   = hvd_qq;
    assign VID_RGB_o   = rgb_q;
    assign DBG_STATE_o = state;

endmodule

// File: tb/tb_starfield_gen.sv
// tb_starfield_gen
// Four starfield_gen instances with different parameters share one input
// stream. A sample-level reference model builds the expected output for each
// input sample. The bench queues that value and compares it against the
// outputs two cycles later. Hand-computed first pixels of the first two
// frames are also checked directly.
module tb_starfield_gen;

    localparam int W = 99;  // {hvd[2:0], rgb3, rgb2, rgb1, rgb0}

    localparam logic [16:0] P0_SEED = 17'h1FFFF;
    localparam logic [7:0]  P0_THR  = 8'hFF;
    localparam logic [9:0]  P0_SPD  = 10'd0;
    localparam logic [16:0] P1_SEED = 17'h1FFFF;
    localparam logic [7:0]  P1_THR  = 8'hFF;
    localparam logic [9:0]  P1_SPD  = 10'd1;
    localparam logic [16:0] P2_SEED = 17'h1ACE1;
    localparam logic [7:0]  P2_THR  = 8'h80;
    localparam logic [9:0]  P2_SPD  = 10'd500;
    localparam logic [16:0] P3_SEED = 17'h00000;
    localparam logic [7:0]  P3_THR  = 8'h00;
    localparam logic [9:0]  P3_SPD  = 10'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hvd_in;
    logic [2:0]  hvd_o [4];
    logic [23:0] rgb_o [4];
    logic [1:0]  st_o  [4];

    always #5 clk = ~clk;

    starfield_gen #(.SEED(P0_SEED), .THRESH(P0_THR), .SPEED(P0_SPD)) u0 (
        .CLK_i(clk), .RST_N_i(rst_n), .VID_HVD_i(hvd_in),
        .VID_HVD_o(hvd_o[0]), .VID_RGB_o(rgb_o[0]), .DBG_STATE_o(st_o[0]));
    starfield_gen #(.SEED(P1_SEED), .THRESH(P1_THR), .SPEED(P1_SPD)) u1 (
        .CLK_i(clk), .RST_N_i(rst_n), .VID_HVD_i(hvd_in),
        .VID_HVD_o(hvd_o[1]), .VID_RGB_o(rgb_o[1]), .DBG_STATE_o(st_o[1]));
    starfield_gen #(.SEED(P2_SEED), .THRESH(P2_THR), .SPEED(P2_SPD)) u2 (
        .CLK_i(clk), .RST_N_i(rst_n), .VID_HVD_i(hvd_in),
        .VID_HVD_o(hvd_o[2]), .VID_RGB_o(rgb_o[2]), .DBG_STATE_o(st_o[2]));
    starfield_gen #(.SEED(P3_SEED), .THRESH(P3_THR), .SPEED(P3_SPD)) u3 (
        .CLK_i(clk), .RST_N_i(rst_n), .VID_HVD_i(hvd_in),
        .VID_HVD_o(hvd_o[3]), .VID_RGB_o(rgb_o[3]), .DBG_STATE_o(st_o[3]));

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [16:0] m_seed  [4];
    logic [7:0]  m_thr   [4];
    logic [9:0]  m_spd   [4];
    logic [16:0] m_lfsr  [4];
    logic [7:0]  m_frame [4];
    logic [9:0]  m_base  [4];
    logic [9:0]  m_skip  [4];
    logic        m_armed [4];
    logic        m_prev_vs;

    function automatic logic [16:0] lfsr_step(input logic [16:0] x);
        if (x == 17'h0) return 17'h1;
        return {x[15:0], x[16] ^ x[13]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_lfsr[k]  = m_seed[k];
            m_frame[k] = 8'h00;
            m_base[k]  = 10'd0;
            m_skip[k]  = 10'd0;
            m_armed[k] = 1'b0;
        end
        m_prev_vs = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);  // outputs are zero in the cycle after release
    endtask

    // First two DE pixels of output frames 1 and 2, per instance.
    logic [23:0] cap [3][2][4];
    int          cap_frame = 0;
    int          cap_idx   = 0;
    logic        cap_prev_vs = 1'b0;

    // ---------------- driver ----------------
    task automatic step(input logic [2:0] hvd);
        logic [W-1:0] e;
        logic [W-1:0] old;
        logic         vs_rise;
        logic [7:0]   lum;
        logic [23:0]  rgb;
        hvd_in = hvd;
        e = '0;
        e[98:96] = hvd;
        vs_rise   = hvd[1] & ~m_prev_vs;
        m_prev_vs = hvd[1];
        for (int k = 0; k < 4; k++) begin
            rgb = 24'h0;
            if (vs_rise) begin
                m_frame[k] = m_frame[k] + 8'd1;
                m_base[k]  = m_base[k] + m_spd[k];
                m_skip[k]  = m_base[k];
                m_lfsr[k]  = m_seed[k];
                m_armed[k] = 1'b1;
            end else if (m_armed[k]) begin
                if (hvd[0]) begin
                    lum = m_lfsr[k][7:0] + m_frame[k];
                    if (m_lfsr[k][16:9] >= m_thr[k]) rgb = {lum, lum, lum};
                    m_lfsr[k] = lfsr_step(m_lfsr[k]);
                    m_skip[k] = 10'd0;
                end else if (m_skip[k] != 10'd0) begin
                    m_lfsr[k] = lfsr_step(m_lfsr[k]);
                    m_skip[k] = m_skip[k] - 10'd1;
                end
            end
            e[k*24 +: 24] = rgb;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            old = exp_q.pop_front();
            check("hvd", {29'd0, hvd_o[0]}, {29'd0, old[98:96]});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rgb%0d", k), {8'd0, rgb_o[k]}, {8'd0, old[k*24 +: 24]});
            end
        end
        exp_q.push_back(e);
        if (hvd_o[0][1] && !cap_prev_vs) begin
            cap_frame++;
            cap_idx = 0;
        end
        cap_prev_vs = hvd_o[0][1];
        if (hvd_o[0][0] && cap_frame >= 1 && cap_frame <= 2 && cap_idx < 2) begin
            for (int k = 0; k < 4; k++) cap[cap_frame][cap_idx][k] = rgb_o[k];
            cap_idx++;
        end
    endtask

    // Vertical blanking (VS high for its first 6 samples), then lines of DE
    // followed by horizontal blanking with an HS pulse.
    task automatic run_frame(input int vblank, input int nlines, input int de_len,
                             input int hblank, input bit vs_with_de);
        for (int i = 0; i < vblank; i++) begin
            step({1'b0, (i < 6), (i == 0) && vs_with_de});
        end
        for (int l = 0; l < nlines; l++) begin
            for (int i = 0; i < de_len; i++) step(3'b001);
            for (int i = 0; i < hblank; i++) step({(i >= 10 && i < 20), 2'b00});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [16:0] x;
        logic [7:0]  l2;
        logic [23:0] exp_u2;

        m_seed[0] = P0_SEED; m_thr[0] = P0_THR; m_spd[0] = P0_SPD;
        m_seed[1] = P1_SEED; m_thr[1] = P1_THR; m_spd[1] = P1_SPD;
        m_seed[2] = P2_SEED; m_thr[2] = P2_THR; m_spd[2] = P2_SPD;
        m_seed[3] = P3_SEED; m_thr[3] = P3_THR; m_spd[3] = P3_SPD;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 4; k++) cap[f][i][k] = 24'hABCDEF;

        rst_n  = 1'b0;
        hvd_in = 3'b001;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hvd", {29'd0, hvd_o[0]}, 32'd0);
        check("rst_rgb", {8'd0, rgb_o[3]}, 32'd0);
        check("rst_state", {30'd0, st_o[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DE before any VS: black, synchros pass through.
        for (int i = 0; i < 6; i++) step(3'b001);

        // Frame 1: 100 skip-capable cycles, two 720-pixel lines, 138 hblank.
        run_frame(101, 2, 720, 138, 1'b0);
        // Frame 2: short frame for the scroll check.
        run_frame(30, 1, 40, 20, 1'b0);
        step(3'b000);
        step(3'b000);

        // Hand-computed first pixels.
        check("f1_u0_px0", {8'd0, cap[1][0][0]}, 32'h000000);
        check("f1_u0_px1", {8'd0, cap[1][1][0]}, 32'hFFFFFF);
        check("f1_u1_px0", {8'd0, cap[1][0][1]}, 32'hFFFFFF);
        check("f1_u1_px1", {8'd0, cap[1][1][1]}, 32'hFDFDFD);
        check("f1_u3_px0", {8'd0, cap[1][0][3]}, 32'h050505);
        check("f2_u0_px0", {8'd0, cap[2][0][0]}, 32'h010101);
        check("f2_u1_px0", {8'd0, cap[2][0][1]}, 32'hFEFEFE);
        check("f2_u3_px0", {8'd0, cap[2][0][3]}, 32'h222222);
        x = P2_SEED;
        for (int i = 0; i < 100; i++) x = lfsr_step(x);
        l2 = x[7:0] + 8'd1;
        exp_u2 = (x[16:9] >= P2_THR) ? {l2, l2, l2} : 24'h0;
        check("f1_u2_px0", {8'd0, cap[1][0][2]}, {8'd0, exp_u2});

        // Reset in the middle of an active line.
        for (int i = 0; i < 10; i++) step(3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_hvd", {29'd0, hvd_o[0]}, 32'd0);
        check("amid_rgb3", {8'd0, rgb_o[3]}, 32'd0);
        check("amid_state", {30'd0, st_o[3]}, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Black until VS, then a frame whose VS edge coincides with DE.
        for (int i = 0; i < 8; i++) step(3'b001);
        run_frame(12, 1, 30, 10, 1'b1);
        run_frame(12, 2, 25, 8, 1'b0);
        for (int i = 0; i < 4; i++) step(3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
